hamming_secded_dec_stream: RTL and testbench

HAMMING_SECDED_DEC_STREAM -- requirements
Module: hamming_secded_dec_stream

---
 rtl/hamming_secded_dec_stream.sv | 117 +++++++++++
 tb/tb_hamming_secded_dec_stream.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_dec_stream.sv
// hamming_secded_dec_stream: two-stage streaming Hamming SECDED decoder with sideband and error counters
module hamming_secded_dec_stream #(
    parameter int R      = 3,
    parameter int SIDE_W = 1,
    parameter int CNT_W  = 16,
    localparam int N     = 2**R - 1,
    localparam int K     = N - R
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [N:0]        i_code,
    input  logic [SIDE_W-1:0] i_side,
    input  logic              i_bypass,
    input  logic              i_cnt_clr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [K-1:0]      o_data,
    output logic [SIDE_W-1:0] o_side,
    output logic              o_sec,
    output logic              o_ded,
    output logic [CNT_W-1:0]  o_cnt_sec,
    output logic [CNT_W-1:0]  o_cnt_ded
);
    logic              adv, hs;
    logic              v1_q, par1_q, byp1_q, par_d;
    logic [R-1:0]      syn1_q, syn_d;
    logic [N:0]        code1_q;
    logic [SIDE_W-1:0] side1_q, side2_q;
    logic              v2_q, sec2_q, ded2_q, sec_d, ded_d, fix;
    logic [K-1:0]      data_d, data2_q;
    logic [CNT_W-1:0]  cnt_sec_q, cnt_ded_q, cnt_sec_d, cnt_ded_d;

    // Whole pipeline moves together whenever the output slot is free or being taken.
    assign adv     = !v2_q | i_ready;
    assign hs      = v2_q & i_ready;
    assign o_ready = adv;

    // Syndrome is the XOR of the indices of all set Hamming positions; parity covers every bit.
    always_comb begin
        syn_d = '0;
        for (int p = 1; p <= N; p++)
            if (i_code[p-1]) syn_d = syn_d ^ R'(p);
        par_d = ^i_code;
    end

    // Classify the error and extract data bits, flipping the bit the syndrome points at.
    always_comb begin
        int j;
        sec_d  = v1_q & par1_q;
        ded_d  = v1_q & (syn1_q != '0) & !par1_q;
        fix    = !byp1_q & par1_q;
        data_d = '0;
        j      = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                data_d[j] = code1_q[p-1] ^ (fix & (syn1_q == R'(p)));
                j++;
            end
        end
    end

    // Saturating counters of delivered words; clear overrides any increment.
    always_comb begin
        cnt_sec_d = i_cnt_clr ? '0 : (hs & sec2_q & ~&cnt_sec_q) ? cnt_sec_q + CNT_W'(1) : cnt_sec_q;
        cnt_ded_d = i_cnt_clr ? '0 : (hs & ded2_q & ~&cnt_ded_q) ? cnt_ded_q + CNT_W'(1) : cnt_ded_q;
    end

    // Pipeline registers: stage 1 holds syndrome and raw word, stage 2 holds decoded result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q    <= 1'b0;
            syn1_q  <= '0;
            par1_q  <= 1'b0;
            code1_q <= '0;
            side1_q <= '0;
            byp1_q  <= 1'b0;
            v2_q    <= 1'b0;
            data2_q <= '0;
            side2_q <= '0;
            sec2_q  <= 1'b0;
            ded2_q  <= 1'b0;
        end else if (adv) begin
            v1_q    <= i_valid;
            syn1_q  <= syn_d;
            par1_q  <= par_d;
            code1_q <= i_code;
            side1_q <= i_side;
            byp1_q  <= i_bypass;
            v2_q    <= v1_q;
            data2_q <= data_d;
            side2_q <= side1_q;
            sec2_q  <= sec_d;
            ded2_q  <= ded_d;
        end
    end

    // Error counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_sec_q <= '0;
            cnt_ded_q <= '0;
        end else begin
            cnt_sec_q <= cnt_sec_d;
            cnt_ded_q <= cnt_ded_d;
        end
    end

    assign o_valid   = v2_q;
    assign o_data    = data2_q;
    assign o_side    = side2_q;
    assign o_sec     = sec2_q;
    assign o_ded     = ded2_q;
    assign o_cnt_sec = cnt_sec_q;
    assign o_cnt_ded = cnt_ded_q;
endmodule

// File: tb/tb_hamming_secded_dec_stream.sv
// tb_hamming_secded_dec_stream: scoreboard bench for the streaming SECDED decoder (R=3)
module tb_hamming_secded_dec_stream;
    logic        clk = 0, rst_n = 0, i_valid = 0, i_bypass = 0, i_cnt_clr = 0, i_ready = 1;
    logic [7:0]  i_code = '0;
    logic [0:0]  i_side = '0;
    logic        o_ready, o_valid, o_sec, o_ded;
    logic [3:0]  o_data;
    logic [0:0]  o_side;
    logic [15:0] o_cnt_sec, o_cnt_ded;
    logic        o2_ready, o2_valid, o2_sec, o2_ded;
    logic [3:0]  o2_data;
    logic [0:0]  o2_side;
    logic [1:0]  o2_cnt_sec, o2_cnt_ded;

    typedef struct packed {logic [3:0] d; logic s; logic sec; logic ded;} exp_t;
    exp_t        sbq[$];
    int          checks = 0, errors = 0, delivered = 0;
    logic [15:0] ec_sec = '0, ec_ded = '0;
    logic [1:0]  ec2_sec = '0, ec2_ded = '0;
    bit          rand_rdy = 0;

    hamming_secded_dec_stream #(.R(3), .SIDE_W(1), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_code(i_code),
        .i_side(i_side), .i_bypass(i_bypass), .i_cnt_clr(i_cnt_clr), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_side(o_side), .o_sec(o_sec), .o_ded(o_ded),
        .o_cnt_sec(o_cnt_sec), .o_cnt_ded(o_cnt_ded));

    hamming_secded_dec_stream #(.R(3), .SIDE_W(1), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o2_ready), .i_code(i_code),
        .i_side(i_side), .i_bypass(i_bypass), .i_cnt_clr(i_cnt_clr), .o_valid(o2_valid),
        .i_ready(i_ready), .o_data(o2_data), .o_side(o2_side), .o_sec(o2_sec), .o_ded(o2_ded),
        .o_cnt_sec(o2_cnt_sec), .o_cnt_ded(o2_cnt_ded));

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] d, input logic s, input logic sec, input logic ded);
        exp_t e;
        e.d = d; e.s = s; e.sec = sec; e.ded = ded;
        return e;
    endfunction

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        c = '0;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        c[7] = ^c[6:0];
        return c;
    endfunction

    function automatic logic [3:0] extract(input logic [7:0] c);
        return {c[6], c[5], c[4], c[2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random downstream backpressure when enabled
    always @(posedge clk) begin
        #1;
        if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: every valid cycle must match the queue head; counters tracked by model
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            ec_sec = '0; ec_ded = '0; ec2_sec = '0; ec2_ded = '0;
        end else begin
            checks++;
            if (o_cnt_sec !== ec_sec || o_cnt_ded !== ec_ded || o2_cnt_sec !== ec2_sec || o2_cnt_ded !== ec2_ded) begin
                errors++;
                $display("FAIL counters got sec=%0d ded=%0d sat_sec=%0d sat_ded=%0d expected %0d %0d %0d %0d",
                         o_cnt_sec, o_cnt_ded, o2_cnt_sec, o2_cnt_ded, ec_sec, ec_ded, ec2_sec, ec2_ded);
            end
            if (o_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL out_word unexpected word d=%h s=%h", o_data, o_side);
                end else begin
                    if (o_data !== sbq[0].d || o_side !== sbq[0].s || o_sec !== sbq[0].sec || o_ded !== sbq[0].ded) begin
                        errors++;
                        $display("FAIL out_word got d=%h s=%h sec=%b ded=%b expected d=%h s=%h sec=%b ded=%b",
                                 o_data, o_side, o_sec, o_ded, sbq[0].d, sbq[0].s, sbq[0].sec, sbq[0].ded);
                    end
                    if (i_ready) begin
                        if (sbq[0].sec) begin ec_sec++; if (ec2_sec != 2'd3) ec2_sec++; end
                        if (sbq[0].ded) begin ec_ded++; if (ec2_ded != 2'd3) ec2_ded++; end
                        void'(sbq.pop_front());
                        delivered++;
                    end
                end
            end
            if (i_cnt_clr) begin
                ec_sec = '0; ec_ded = '0; ec2_sec = '0; ec2_ded = '0;
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic s, input logic byp, input exp_t e);
        bit ok;
        ok = 0;
        i_valid = 1; i_code = c; i_side = s; i_bypass = byp;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (o_ready) begin
                sbq.push_back(e);
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL input_accept got no handshake within 200 cycles expected accept");
        end
        tick();
        i_valid = 0;
    endtask

    task automatic send_word(input int kind, input logic [3:0] d, input logic s, input logic byp);
        logic [7:0] c;
        exp_t       e;
        int         a, b;
        c = encode(d);
        case (kind)
            0: e = mk(d, s, 1'b0, 1'b0);
            1: begin
                a = $urandom_range(0, 6);
                c[a] = ~c[a];
                e = mk(byp ? extract(c) : d, s, 1'b1, 1'b0);
            end
            2: begin
                c[7] = ~c[7];
                e = mk(d, s, 1'b1, 1'b0);
            end
            default: begin
                a = $urandom_range(0, 7);
                b = (a + $urandom_range(1, 7)) % 8;
                c[a] = ~c[a];
                c[b] = ~c[b];
                e = mk(extract(c), s, 1'b0, 1'b1);
            end
        endcase
        send(c, s, byp, e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d words outstanding expected 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (o_valid !== 0 || o_sec !== 0 || o_ded !== 0 || o_data !== 0 || o_side !== 0 ||
            o_cnt_sec !== 0 || o_cnt_ded !== 0 || o_ready !== 1) begin
            errors++;
            $display("FAIL reset_state got v=%b sec=%b ded=%b d=%h s=%h cs=%0d cd=%0d rdy=%b expected all 0 rdy=1",
                     o_valid, o_sec, o_ded, o_data, o_side, o_cnt_sec, o_cnt_ded, o_ready);
        end
        tick();
        rst_n = 1;
    endtask

    task automatic test_latency();
        send_word(0, 4'h6, 1'b0, 1'b0);
        checks++;
        if (o_valid !== 0) begin
            errors++;
            $display("FAIL latency_early got o_valid=%b expected 0", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1) begin
            errors++;
            $display("FAIL latency_2 got o_valid=%b expected 1", o_valid);
        end
        drain();
    endtask

    task automatic test_vectors();
        send(8'h55, 1'b1, 1'b0, mk(4'hB, 1'b1, 1'b0, 1'b0));
        send(8'h45, 1'b0, 1'b0, mk(4'hB, 1'b0, 1'b1, 1'b0));
        drain();
        checks++;
        if (o_cnt_sec !== 16'd1) begin
            errors++;
            $display("FAIL cnt_sec_after_45 got %0d expected 1", o_cnt_sec);
        end
        send(8'h45, 1'b1, 1'b1, mk(4'h9, 1'b1, 1'b1, 1'b0));
        send(8'hD5, 1'b0, 1'b0, mk(4'hB, 1'b0, 1'b1, 1'b0));
        send(8'h44, 1'b1, 1'b0, mk(4'h9, 1'b1, 1'b0, 1'b1));
        drain();
        checks++;
        if (o_cnt_sec !== 16'd3 || o_cnt_ded !== 16'd1) begin
            errors++;
            $display("FAIL cnt_after_vectors got sec=%0d ded=%0d expected 3 1", o_cnt_sec, o_cnt_ded);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = delivered;
        rand_rdy = 1;
        for (int i = 0; i < 10; i++)
            send_word($urandom_range(0, 3), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
        rand_rdy = 0;
        tick();
        i_ready = 1;
        checks++;
        if (delivered - start != 10) begin
            errors++;
            $display("FAIL stream_count got %0d words expected 10", delivered - start);
        end
    endtask

    task automatic test_counters();
        i_cnt_clr = 1;
        tick();
        i_cnt_clr = 0;
        for (int i = 0; i < 5; i++) send_word(1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        drain();
        tick();
        checks++;
        if (o2_cnt_sec !== 2'd3 || o_cnt_sec !== 16'd5) begin
            errors++;
            $display("FAIL cnt_saturate got sat=%0d wide=%0d expected 3 5", o2_cnt_sec, o_cnt_sec);
        end
        send_word(2, 4'hA, 1'b0, 1'b0);
        tick();
        i_cnt_clr = 1;
        tick();
        i_cnt_clr = 0;
        checks++;
        if (o_cnt_sec !== 0 || o2_cnt_sec !== 0 || o_cnt_ded !== 0) begin
            errors++;
            $display("FAIL cnt_clear_wins got sec=%0d sat=%0d ded=%0d expected 0 0 0", o_cnt_sec, o2_cnt_sec, o_cnt_ded);
        end
    endtask

    task automatic test_reset_midstream();
        send_word(1, 4'h3, 1'b1, 1'b0);
        drain();
        tick();
        i_ready = 0;
        send_word(0, 4'h1, 1'b0, 1'b0);
        send_word(3, 4'h2, 1'b1, 1'b0);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (o_valid !== 0 || o_cnt_sec !== 0 || o_cnt_ded !== 0 || o_ready !== 1) begin
            errors++;
            $display("FAIL reset_midstream got v=%b cs=%0d cd=%0d rdy=%b expected 0 0 0 1",
                     o_valid, o_cnt_sec, o_cnt_ded, o_ready);
        end
        repeat (2) tick();
        i_ready = 1;
        rst_n = 1;
        checks++;
        if (o_ready !== 1) begin
            errors++;
            $display("FAIL ready_after_release got %b expected 1", o_ready);
        end
        test_latency();
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_counters();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
